// File: rtl/svm_decision_funct_if.sv
// svm_decision_funct_if: bus between the SVM memory controller and the decision-function block.
interface svm_decision_funct_if #(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 784,
  parameter int NUM_OF_SV     = 10,
  parameter int XLEN_COEF     = 16,
  parameter int ACC_W         = 48
);
  logic                             decision_funct_en;
  logic                             stall_MEM;
  logic [XLEN_PIXEL-1:0]            x_test;
  logic [XLEN_PIXEL-1:0]            sv_pixel;
  logic [XLEN_COEF-1:0]             alpha;
  logic [ACC_W-1:0]                 bias;
  logic [$clog2(NUM_OF_PIXELS)-1:0] pix_idx;
  logic [$clog2(NUM_OF_SV)-1:0]     sv_idx;
  logic                             busy;
  logic [ACC_W-1:0]                 decision;
  logic                             class_out;
  logic                             done;
  modport master (
    output decision_funct_en, stall_MEM, x_test, sv_pixel, alpha, bias,
    input  pix_idx, sv_idx, busy, decision, class_out, done
  );
  modport slave (
    input  decision_funct_en, stall_MEM, x_test, sv_pixel, alpha, bias,
    output pix_idx, sv_idx, busy, decision, class_out, done
  );
endinterface

// File: rtl/svm_decision_funct.sv
// svm_decision_funct: linear-kernel SVM decision value = sum(alpha_k * <x, sv_k>) + bias.
module svm_decision_funct #(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 784,
  parameter int NUM_OF_SV     = 10,
  parameter int XLEN_COEF     = 16,
  parameter int ACC_W         = 48
) (
  input logic                  clk,
  input logic                  rst,
  svm_decision_funct_if.slave  bus
);
  localparam int PW = $clog2(NUM_OF_PIXELS);
  localparam int SW = $clog2(NUM_OF_SV);
  localparam int DW = 2*XLEN_PIXEL + PW;
  typedef enum logic [2:0] {IDLE, DOT, SCALE, BIAS, DONE} state_t;
  state_t                     state, state_nx;
  logic [PW-1:0]              pix_idx;
  logic [SW-1:0]              sv_idx;
  logic [DW-1:0]              dot;
  logic signed [DW+XLEN_COEF:0] prod;
  logic signed [ACC_W-1:0]    sum, total, decision;
  logic                       class_out, last_pix, last_sv;
  assign last_pix = pix_idx == PW'(NUM_OF_PIXELS-1);
  assign last_sv  = sv_idx == SW'(NUM_OF_SV-1);
  // dot is unsigned, so a zero MSB is prepended before the signed multiply
  assign prod  = $signed({1'b0, dot}) * $signed(bus.alpha);
  assign total = sum + $signed(bus.bias);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.decision_funct_en ? DOT : IDLE;
      DOT:     state_nx = (!bus.stall_MEM && last_pix) ? SCALE : DOT;
      SCALE:   state_nx = last_sv ? BIAS : DOT;
      BIAS:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_idx   <= '0;
      sv_idx    <= '0;
      dot       <= '0;
      sum       <= '0;
      decision  <= '0;
      class_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.decision_funct_en) begin
          pix_idx <= '0;
          sv_idx  <= '0;
          dot     <= '0;
          sum     <= '0;
        end
        DOT: if (!bus.stall_MEM) begin
          dot     <= dot + DW'(bus.x_test) * DW'(bus.sv_pixel);
          pix_idx <= last_pix ? '0 : pix_idx + PW'(1);
        end
        SCALE: begin
          sum <= sum + ACC_W'(prod);
          dot <= '0;
          if (!last_sv) sv_idx <= sv_idx + SW'(1);
        end
        BIAS: begin
          decision  <= total;
          class_out <= ~total[ACC_W-1];
        end
        default: ;
      endcase
    end
  end
  assign bus.pix_idx   = pix_idx;
  assign bus.sv_idx    = sv_idx;
  assign bus.busy      = state != IDLE;
  assign bus.done      = state == DONE;
  assign bus.decision  = decision;
  assign bus.class_out = class_out;
endmodule

// File: tb/tb_svm_decision_funct.sv
// tb_svm_decision_funct: directed checks of a small (4 px, 2 SV) and a default-size decision block.
module tb_svm_decision_funct;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  svm_decision_funct_if #(.NUM_OF_PIXELS(4), .NUM_OF_SV(2)) s ();
  svm_decision_funct_if b ();
  svm_decision_funct #(.NUM_OF_PIXELS(4), .NUM_OF_SV(2)) dut_s (.clk(clk), .rst(rst), .bus(s));
  svm_decision_funct dut_b (.clk(clk), .rst(rst), .bus(b));

  logic [7:0]  xv  [4]    = '{8'd1, 8'd2, 8'd3, 8'd4};
  logic [7:0]  svp [2][4] = '{'{8'd1, 8'd1, 8'd1, 8'd1}, '{8'd2, 8'd0, 8'd0, 8'd0}};
  logic [15:0] al  [2]    = '{16'd3, 16'hFFEC};

  assign s.x_test   = xv[s.pix_idx];
  assign s.sv_pixel = svp[s.sv_idx][s.pix_idx];
  assign s.alpha    = al[s.sv_idx];
  assign b.x_test   = 8'hFF;
  assign b.sv_pixel = 8'hFF;
  assign b.alpha    = 16'h8000;
  assign b.bias     = '0;
  assign b.stall_MEM = 1'b0;

  int nchk = 0, nerr = 0, cyc_g = 0;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint dec_s();
    return longint'($signed(s.decision));
  endfunction

  function automatic longint dec_b();
    return longint'($signed(b.decision));
  endfunction

  // reference: sum over SVs of alpha * (x . sv) + bias, in plain 64-bit arithmetic
  function automatic longint model_s();
    longint acc = longint'($signed(s.bias));
    for (int k = 0; k < 2; k++) begin
      longint d = 0;
      for (int i = 0; i < 4; i++) d += longint'(xv[i]) * longint'(svp[k][i]);
      acc += d * longint'($signed(al[k]));
    end
    return acc;
  endfunction

  function automatic longint model_b();
    longint acc = 0;
    for (int k = 0; k < 10; k++) begin
      longint d = 0;
      for (int i = 0; i < 784; i++) d += 64'd255 * 64'd255;
      acc += d * -64'sd32768;
    end
    return acc;
  endfunction

  // decision must hold its last result except on the done cycle, where it equals the model
  longint held_s = 0, held_b = 0;
  bit cls_s = 1'b0, cls_b = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst dec_s", dec_s(), 0);
      chk("rst done_s", longint'(s.done), 0);
      chk("rst busy_s", longint'(s.busy), 0);
      chk("rst dec_b", dec_b(), 0);
      held_s = 0; cls_s = 1'b0; held_b = 0; cls_b = 1'b0;
    end else begin
      if (s.done) begin held_s = model_s(); cls_s = held_s >= 0; end
      if (b.done) begin held_b = model_b(); cls_b = held_b >= 0; end
      chk("dec_s", dec_s(), held_s);
      chk("cls_s", longint'(s.class_out), longint'(cls_s));
      chk("dec_b", dec_b(), held_b);
      chk("cls_b", longint'(b.class_out), longint'(cls_b));
    end
  end

  bit stall_en = 1'b0;
  int c0 = 0, c1 = 0;
  always @(negedge clk) begin
    if (!s.busy) begin c0 = 0; c1 = 0; s.stall_MEM = 1'b0; end
    else if (stall_en && s.sv_idx == 1'd0 && s.pix_idx == 2'd2 && c0 < 3) begin c0++; s.stall_MEM = 1'b1; end
    else if (stall_en && s.sv_idx == 1'd1 && s.pix_idx == 2'd0 && c1 < 1) begin c1++; s.stall_MEM = 1'b1; end
    else s.stall_MEM = 1'b0;
  end

  task automatic wait_s(output bit seen, output int n);
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk); n++;
      @(negedge clk); seen = s.done;
    end
  endtask

  task automatic run_s(input string tag, input bit st, input int lat, input longint dec, input bit cls);
    bit seen;
    int n;
    stall_en = st;
    @(negedge clk); s.decision_funct_en = 1'b1;
    @(negedge clk); s.decision_funct_en = 1'b0;
    wait_s(seen, n);
    chk({tag, " done"}, longint'(seen), 1);
    chk({tag, " latency"}, longint'(n), longint'(lat));
    chk({tag, " decision"}, dec_s(), dec);
    chk({tag, " class"}, longint'(s.class_out), longint'(cls));
    @(negedge clk);
    chk({tag, " busy after"}, longint'(s.busy), 0);
    stall_en = 1'b0;
  endtask

  initial begin
    bit seen, any;
    int n;
    int t [3];
    s.decision_funct_en = 1'b0;
    b.decision_funct_en = 1'b0;
    s.bias = 48'd10;
    #1 rst = 1'b0;
    #2;
    chk("reset pix_idx", longint'(s.pix_idx), 0);
    chk("reset sv_idx", longint'(s.sv_idx), 0);
    chk("reset busy", longint'(s.busy), 0);
    chk("reset done", longint'(s.done), 0);
    chk("reset class", longint'(s.class_out), 0);
    chk("reset decision", dec_s(), 0);
    chk("reset big busy", longint'(b.busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_s("zero", 1'b0, 11, 0, 1'b1);
    s.bias = 48'd5;
    run_s("basic", 1'b0, 11, -5, 1'b0);
    run_s("stall", 1'b1, 15, -5, 1'b0);

    @(negedge clk); s.decision_funct_en = 1'b1;
    @(negedge clk); s.decision_funct_en = 1'b0;
    n = 0;
    while (s.sv_idx != 1'd1 && n < 50) begin @(negedge clk); n++; end
    chk("mid reached sv1", longint'(s.sv_idx), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid rst busy", longint'(s.busy), 0);
    chk("mid rst pix_idx", longint'(s.pix_idx), 0);
    chk("mid rst sv_idx", longint'(s.sv_idx), 0);
    chk("mid rst decision", dec_s(), 0);
    chk("mid rst class", longint'(s.class_out), 0);
    chk("mid rst done", longint'(s.done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    any = 1'b0;
    repeat (4) begin @(negedge clk); any |= s.busy | s.done; end
    chk("idle after rst", longint'(any), 0);
    run_s("fresh", 1'b0, 11, -5, 1'b0);

    @(negedge clk); s.decision_funct_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_s(seen, n);
      chk("held done", longint'(seen), 1);
      chk("held decision", dec_s(), -5);
      t[k] = cyc_g;
    end
    chk("period 1", longint'(t[1] - t[0]), 13);
    chk("period 2", longint'(t[2] - t[1]), 13);
    repeat (3) @(negedge clk);
    s.decision_funct_en = 1'b0;
    wait_s(seen, n);
    chk("drop completes", longint'(seen), 1);
    chk("drop decision", dec_s(), -5);
    any = 1'b0;
    repeat (20) begin @(negedge clk); any |= s.busy; end
    chk("drop stays idle", longint'(any), 0);

    @(negedge clk); b.decision_funct_en = 1'b1;
    @(negedge clk); b.decision_funct_en = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 9000) begin
      @(posedge clk); n++;
      @(negedge clk); seen = b.done;
    end
    chk("wide done", longint'(seen), 1);
    chk("wide latency", longint'(n), 7851);
    chk("wide decision", dec_b(), -64'sd16704995328000);
    chk("wide class", longint'(b.class_out), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/svm_decision_funct.md
Name: svm_decision_funct

Overview:
- Downstream consumer of the SVM memory controller. Starts when `decision_funct_en` is high.
- Streams one test-vector pixel and one support-vector pixel per unstalled cycle and forms the linear-kernel dot product for each support vector.
- Scales each dot product by that SV's signed coefficient (alpha·y), accumulates across all SVs and adds the bias.
- Outputs the signed decision value and a class bit for the next cascade stage.

Parameters:
- XLEN_PIXEL, 8, pixel width (unsigned).
- NUM_OF_PIXELS, 784, pixels per vector.
- NUM_OF_SV, 10, support vectors evaluated.
- XLEN_COEF, 16, signed alpha·y coefficient width.
- ACC_W, 48, signed accumulator, bias and decision width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- decision_funct_en  in  1  level start/enable from the memory controller.
- stall_MEM  in  1  high = pixel inputs invalid this cycle; hold state.
- x_test  in  XLEN_PIXEL  test pixel at pix_idx.
- sv_pixel  in  XLEN_PIXEL  pixel pix_idx of support vector sv_idx.
- alpha  in  XLEN_COEF  signed coefficient of sv_idx.
- bias  in  ACC_W  signed bias term.
- pix_idx  out  clog2(NUM_OF_PIXELS)  pixel address.
- sv_idx  out  clog2(NUM_OF_SV)  support-vector address.
- busy  out  1  high in any state except IDLE.
- decision  out  ACC_W  signed decision value.
- class_out  out  1  1 when decision >= 0.
- done  out  1  one-cycle pulse when decision and class_out are updated.

Behaviour:
- Reset: while rst=0, force all of the following to 0 immediately (asynchronous), including mid-operation:
  - state to IDLE;
  - pix_idx, sv_idx, busy, decision, class_out, done;
  - internal dot and sum accumulators.
- Registered FSM: IDLE, DOT, SCALE, BIAS, DONE.
- IDLE:
  - If decision_funct_en=1 at the edge, go to DOT and clear the dot accumulator, sum accumulator, pix_idx and sv_idx.
  - Otherwise stay in IDLE.
- DOT, with stall_MEM=1: hold all state, counters and accumulators.
- DOT, with stall_MEM=0:
  - dot += x_test*sv_pixel (unsigned product, zero-extended).
  - If pix_idx = NUM_OF_PIXELS-1, set pix_idx to 0 and go to SCALE; otherwise increment pix_idx.
- Data alignment: x_test, sv_pixel and alpha must be valid in the same cycle their address is presented.
- SCALE (one cycle; stall ignored):
  - sum += signed(dot)*alpha (alpha sampled this cycle); clear dot.
  - If sv_idx = NUM_OF_SV-1, go to BIAS; otherwise increment sv_idx and go to DOT.
- BIAS:
  - decision <= sum + bias.
  - class_out <= ~sign bit of (sum + bias).
  - Go to DONE.
- DONE:
  - done=1 for exactly this cycle; go to IDLE.
  - decision and class_out hold until the next BIAS.
- Widths:
  - dot is 2*XLEN_PIXEL + clog2(NUM_OF_PIXELS) bits unsigned and cannot overflow.
  - The product is sign-extended to ACC_W; ACC_W=48 covers the worst case at default parameters.
  - No saturation; if parameters are changed, they must keep ACC_W sufficient.
- Latency with no stalls: done is high after the NUM_OF_SV*(NUM_OF_PIXELS+1)+1-th rising edge following the edge that samples start.
  - Each stalled cycle adds exactly one cycle.
  - Result-to-result period with the enable held high is NUM_OF_SV*(NUM_OF_PIXELS+1)+3.
- Enable during a run: decision_funct_en is ignored outside IDLE. Deasserting it mid-run does not abort; only rst aborts.
- Back-to-back: if the enable is still high in IDLE after DONE, a new run starts and decision is unchanged until its BIAS.
- Zero decision: decision = 0 gives class_out = 1.

Test Plan:
- Basic run (NUM_OF_PIXELS=4, NUM_OF_SV=2, no stall):
  - Stimulus: x=[1,2,3,4]; sv0=[1,1,1,1], alpha0=3; sv1=[2,0,0,0], alpha1=-20; bias=5.
  - Response: decision = 30 - 40 + 5 = -5, class_out=0, done high after the 11th edge after start, busy low again the cycle after.
- Stalls: same vectors with stall_MEM=1 for 3 cycles during sv0 pixel 2 and 1 cycle during sv1 pixel 0 -> decision=-5, done 4 cycles later than the unstalled run.
- Zero boundary: same vectors with bias=10 -> decision=0, class_out=1.
- Worst-case width (default parameters): all pixels 255, all alpha=-32768, bias=0 -> decision = -10*784*65025*32768 exactly, class_out=0, no wrap.
- Reset mid-run: drive rst low for 2 cycles while in DOT of sv1 -> all outputs 0 immediately, no done pulse. A fresh start then yields decision=-5.
- Enable behaviour:
  - decision_funct_en held high -> done pulses every 13 cycles with a constant decision.
  - Dropping the enable mid-run -> the current run still completes, then the block stays in IDLE.
